// File: rtl/ir_nec_pkg.sv
// ir_nec_pkg: shared states, error codes and elaboration-time timing helpers for the NEC receiver
package ir_nec_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_LO,
        S_LEAD_HI,
        S_BIT_LO,
        S_BIT_HI,
        S_STOP_HI,
        S_RPT_LO
    } state_t;

    localparam logic [2:0] E_NONE    = 3'd0;
    localparam logic [2:0] E_LEADER  = 3'd1;
    localparam logic [2:0] E_BIT     = 3'd2;
    localparam logic [2:0] E_INV     = 3'd3;
    localparam logic [2:0] E_TIMEOUT = 3'd4;
    localparam logic [2:0] E_ORPHAN  = 3'd5;

    // Nominal cycle count of an interval given in microseconds
    function automatic longint cyc(input int us, input int clk_hz);
        return longint'(us) * longint'(clk_hz) / 1_000_000;
    endfunction

    // Lower (hi=0) or upper (hi=1) acceptance bound around a nominal cycle count
    function automatic longint win(input longint n, input int tol, input bit hi);
        return hi ? n * (100 + tol) / 100 : n * (100 - tol) / 100;
    endfunction

    // Interval counter saturation point: 12 ms
    function automatic longint t_to(input int clk_hz);
        return cyc(12000, clk_hz);
    endfunction

    function automatic int cnt_w(input int clk_hz);
        return $clog2(t_to(clk_hz) + 1);
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// ir_pulse_timer: synchronises the IR line, detects edges and measures the level that just ended
module ir_pulse_timer
    import ir_nec_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SYNC_STAGES = 2,
    parameter int W           = cnt_w(CLK_HZ)
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         iIR,
    output logic         fall,
    output logic         rise,
    output logic [W-1:0] len,
    output logic         sat
);

    localparam logic [W-1:0] T_TO = W'(t_to(CLK_HZ));

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   lvl;
    logic [W-1:0]           cnt;

    assign lvl  = sync[SYNC_STAGES-1];
    assign fall = prev & ~lvl;
    assign rise = ~prev & lvl;
    assign len  = cnt;
    assign sat  = (cnt == T_TO);

    // Sync chain, edge-detect flop, and a counter that restarts at 1 on each edge so len equals the level length
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync <= '1;
            prev <= 1'b1;
            cnt  <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], iIR};
            prev <= lvl;
            cnt  <= (fall | rise) ? W'(1) : (sat ? cnt : cnt + W'(1));
        end
    end

endmodule

// File: rtl/ir_nec_rx.sv
// ir_nec_rx: NEC infrared frame and repeat-code decoder with inverse check and error classification
module ir_nec_rx
    import ir_nec_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TOL_PCT       = 20,
    parameter int SYNC_STAGES   = 2,
    parameter int CHECK_INV     = 1,
    parameter int REPEAT_WIN_MS = 120
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        iIR,
    output logic [15:0] irAddr,
    output logic [7:0]  irCmd,
    output logic        frame_vld,
    output logic        repeat_vld,
    output logic        err,
    output logic [2:0]  err_code,
    output logic        busy
);

    localparam int W = cnt_w(CLK_HZ);

    localparam logic [W-1:0] LEAD_MIN  = W'(win(cyc(9000, CLK_HZ), TOL_PCT, 1'b0));
    localparam logic [W-1:0] LEAD_MAX  = W'(win(cyc(9000, CLK_HZ), TOL_PCT, 1'b1));
    localparam logic [W-1:0] LHI_MIN   = W'(win(cyc(4500, CLK_HZ), TOL_PCT, 1'b0));
    localparam logic [W-1:0] LHI_MAX   = W'(win(cyc(4500, CLK_HZ), TOL_PCT, 1'b1));
    localparam logic [W-1:0] RHI_MIN   = W'(win(cyc(2250, CLK_HZ), TOL_PCT, 1'b0));
    localparam logic [W-1:0] RHI_MAX   = W'(win(cyc(2250, CLK_HZ), TOL_PCT, 1'b1));
    localparam logic [W-1:0] SHORT_MIN = W'(win(cyc(560, CLK_HZ), TOL_PCT, 1'b0));
    localparam logic [W-1:0] SHORT_MAX = W'(win(cyc(560, CLK_HZ), TOL_PCT, 1'b1));
    localparam logic [W-1:0] ONE_MIN   = W'(win(cyc(1690, CLK_HZ), TOL_PCT, 1'b0));
    localparam logic [W-1:0] ONE_MAX   = W'(win(cyc(1690, CLK_HZ), TOL_PCT, 1'b1));

    localparam longint          RPT_CYC = cyc(REPEAT_WIN_MS * 1000, CLK_HZ);
    localparam int              RW      = $clog2(RPT_CYC + 1);
    localparam logic [RW-1:0]   T_RPT   = RW'(RPT_CYC);

    logic          fall;
    logic          rise;
    logic          edg;
    logic          sat;
    logic [W-1:0]  len;
    logic          ok_lead;
    logic          ok_lhi;
    logic          ok_rhi;
    logic          ok_short;
    logic          ok_one;
    logic          inv_ok;
    state_t        state;
    logic [5:0]    idx;
    logic [31:0]   sr;
    logic [RW-1:0] rpt;

    ir_pulse_timer #(
        .CLK_HZ      (CLK_HZ),
        .SYNC_STAGES (SYNC_STAGES),
        .W           (W)
    ) u_timer (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .iIR   (iIR),
        .fall  (fall),
        .rise  (rise),
        .len   (len),
        .sat   (sat)
    );

    assign edg      = fall | rise;
    assign ok_lead  = (len >= LEAD_MIN)  && (len <= LEAD_MAX);
    assign ok_lhi   = (len >= LHI_MIN)   && (len <= LHI_MAX);
    assign ok_rhi   = (len >= RHI_MIN)   && (len <= RHI_MAX);
    assign ok_short = (len >= SHORT_MIN) && (len <= SHORT_MAX);
    assign ok_one   = (len >= ONE_MIN)   && (len <= ONE_MAX);
    assign inv_ok   = (CHECK_INV == 0) || (sr[23:16] == ~sr[31:24]);
    assign busy     = (state != S_IDLE);

    // Decoder FSM: walks leader, 32 bits and stop burst, reports frames, repeats and aborts as one-cycle pulses
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            sr         <= '0;
            rpt        <= '0;
            irAddr     <= '0;
            irCmd      <= '0;
            frame_vld  <= 1'b0;
            repeat_vld <= 1'b0;
            err        <= 1'b0;
            err_code   <= E_NONE;
        end else begin
            frame_vld  <= 1'b0;
            repeat_vld <= 1'b0;
            err        <= 1'b0;
            if (rpt != '0)
                rpt <= rpt - RW'(1);
            // An edge always takes priority; a saturated len then fails every window
            if (state != S_IDLE && !edg && sat) begin
                err      <= 1'b1;
                err_code <= E_TIMEOUT;
                state    <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (fall)
                            state <= S_LEAD_LO;
                    end
                    S_LEAD_LO: begin
                        if (rise) begin
                            if (ok_lead) begin
                                state <= S_LEAD_HI;
                            end else begin
                                err      <= 1'b1;
                                err_code <= E_LEADER;
                                state    <= S_IDLE;
                            end
                        end
                    end
                    S_LEAD_HI: begin
                        if (fall) begin
                            idx <= '0;
                            if (ok_lhi) begin
                                state <= S_BIT_LO;
                            end else if (ok_rhi) begin
                                state <= S_RPT_LO;
                            end else begin
                                err      <= 1'b1;
                                err_code <= E_LEADER;
                                state    <= S_IDLE;
                            end
                        end
                    end
                    S_BIT_LO: begin
                        if (rise) begin
                            if (!ok_short) begin
                                err      <= 1'b1;
                                err_code <= E_BIT;
                                state    <= S_IDLE;
                            end else if (idx == 6'd32) begin
                                state <= S_STOP_HI;
                                if (inv_ok) begin
                                    frame_vld <= 1'b1;
                                    irAddr    <= sr[15:0];
                                    irCmd     <= sr[23:16];
                                    rpt       <= T_RPT;
                                end else begin
                                    err      <= 1'b1;
                                    err_code <= E_INV;
                                end
                            end else begin
                                state <= S_BIT_HI;
                            end
                        end
                    end
                    S_BIT_HI: begin
                        if (fall) begin
                            if (ok_short || ok_one) begin
                                sr    <= {ok_one, sr[31:1]};
                                idx   <= idx + 6'd1;
                                state <= S_BIT_LO;
                            end else begin
                                err      <= 1'b1;
                                err_code <= E_BIT;
                                state    <= S_IDLE;
                            end
                        end
                    end
                    S_STOP_HI: begin
                        state <= S_IDLE;
                    end
                    S_RPT_LO: begin
                        if (rise) begin
                            state <= S_IDLE;
                            if (!ok_short) begin
                                err      <= 1'b1;
                                err_code <= E_BIT;
                            end else if (rpt != '0) begin
                                repeat_vld <= 1'b1;
                                rpt        <= T_RPT;
                            end else begin
                                err      <= 1'b1;
                                err_code <= E_ORPHAN;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ir_nec_rx.sv
// tb_ir_nec_rx: scoreboard bench for the NEC receiver at a reduced clock of 50 kHz (20 us per cycle)
module tb_ir_nec_rx;

    localparam int CLK_HZ  = 50_000;
    localparam int C_LEAD  = 450;
    localparam int C_LHI   = 225;
    localparam int C_RPT   = 112;
    localparam int C_BURST = 28;
    localparam int C_ZERO  = 28;
    localparam int C_ONE   = 84;
    localparam int C_WIN   = 6000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ir    = 1'b1;
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic        frame_vld;
    logic        repeat_vld;
    logic        err;
    logic [2:0]  err_code;
    logic        busy;
    logic [15:0] ni_addr;
    logic [7:0]  ni_cmd;
    logic        ni_frame_vld;
    logic        ni_repeat_vld;
    logic        ni_err;
    logic [2:0]  ni_err_code;
    logic        ni_busy;

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  code;
        logic [15:0] ea;
        logic [7:0]  ec;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc_n = 0;
    int          err_cyc = 0;
    int          ni_frames = 0;
    int          t0;
    int          n0;
    logic [15:0] m_a = '0;
    logic [7:0]  m_c = '0;

    always #5 clk = ~clk;

    ir_nec_rx #(.CLK_HZ(CLK_HZ)) dut (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .iIR        (ir),
        .irAddr     (addr),
        .irCmd      (cmd),
        .frame_vld  (frame_vld),
        .repeat_vld (repeat_vld),
        .err        (err),
        .err_code   (err_code),
        .busy       (busy)
    );

    ir_nec_rx #(.CLK_HZ(CLK_HZ), .CHECK_INV(0), .SYNC_STAGES(3)) dut_ni (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .iIR        (ir),
        .irAddr     (ni_addr),
        .irCmd      (ni_cmd),
        .frame_vld  (ni_frame_vld),
        .repeat_vld (ni_repeat_vld),
        .err        (ni_err),
        .err_code   (ni_err_code),
        .busy       (ni_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sc(input int n, input int p);
        return n * (100 + p) / 100;
    endfunction

    task automatic hold(input logic lvl, input int n);
        ir = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [1:0] kind, input logic [2:0] code);
        q.push_back('{kind: kind, code: code, ea: m_a, ec: m_c});
    endtask

    task automatic send_rpt();
        hold(1'b0, C_LEAD);
        hold(1'b1, C_RPT);
        hold(1'b0, C_BURST);
        ir = 1'b1;
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [7:0] c, input logic [7:0] inv,
                              input int p, input int lead, input int bad_bit, input int nbits);
        logic [31:0] d = {inv, c, a};
        hold(1'b0, lead);
        hold(1'b1, sc(C_LHI, p));
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, sc(C_BURST, p));
            if (i == bad_bit) begin
                hold(1'b1, 60);
                hold(1'b0, C_BURST);
                ir = 1'b1;
                return;
            end
            hold(1'b1, sc(d[i] ? C_ONE : C_ZERO, p));
        end
        if (nbits == 32)
            hold(1'b0, sc(C_BURST, p));
        ir = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++)
            @(negedge clk);
        check("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_addr"}, 32'(addr), 32'd0);
        check({tag, "_cmd"}, 32'(cmd), 32'd0);
        check({tag, "_code"}, 32'(err_code), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pulses"}, 32'({frame_vld, repeat_vld, err}), 32'd0);
    endtask

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (rst_n && (frame_vld || repeat_vld || err)) begin
            check("exclusive", 32'($countones({frame_vld, repeat_vld, err})), 32'd1);
            if (err)
                err_cyc = cyc_n;
            if (q.size() == 0) begin
                check("unexpected", 32'({frame_vld, repeat_vld, err}), 32'd0);
            end else begin
                e = q.pop_front();
                check("kind", frame_vld ? 32'd1 : (repeat_vld ? 32'd2 : 32'd3), 32'(e.kind));
                if (e.kind == 2'd3)
                    check("err_code", 32'(err_code), 32'(e.code));
                check("addr", 32'(addr), 32'(e.ea));
                check("cmd", 32'(cmd), 32'(e.ec));
            end
        end
    end

    always @(negedge clk)
        if (rst_n && ni_frame_vld)
            ni_frames++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        hold(1'b1, 20);

        push(2'd3, 3'd5);
        send_rpt();
        drain();
        hold(1'b1, 50);

        m_a = 16'h00FF; m_c = 8'h45;
        push(2'd1, 3'd0);
        send_frame(16'h00FF, 8'h45, 8'hBA, 0, C_LEAD, -1, 32);
        drain();
        check("busy_after_frame", 32'(busy), 32'd0);
        hold(1'b1, 2000);

        push(2'd2, 3'd0);
        send_rpt();
        drain();
        hold(1'b1, 50);

        n0 = ni_frames;
        push(2'd3, 3'd3);
        send_frame(16'h1234, 8'h45, 8'hBB, 0, C_LEAD, -1, 32);
        drain();
        hold(1'b1, 10);
        check("noinv_frames", 32'(ni_frames - n0), 32'd1);
        check("noinv_addr", 32'(ni_addr), 32'h1234);
        check("noinv_cmd", 32'(ni_cmd), 32'h45);
        hold(1'b1, 50);

        m_a = 16'hA55A; m_c = 8'h3C;
        push(2'd1, 3'd0);
        send_frame(16'hA55A, 8'h3C, 8'hC3, 18, sc(C_LEAD, 18), -1, 32);
        drain();
        hold(1'b1, 50);

        m_a = 16'h0102; m_c = 8'h10;
        push(2'd1, 3'd0);
        send_frame(16'h0102, 8'h10, 8'hEF, -18, sc(C_LEAD, -18), -1, 32);
        drain();
        hold(1'b1, 50);

        m_a = 16'hBEEF; m_c = 8'h5A;
        push(2'd1, 3'd0);
        send_frame(16'hBEEF, 8'h5A, 8'hA5, 0, 540, -1, 32);
        drain();
        hold(1'b1, 50);

        push(2'd3, 3'd1);
        hold(1'b0, 541);
        ir = 1'b1;
        drain();
        hold(1'b1, 50);

        push(2'd3, 3'd2);
        send_frame(16'h1111, 8'h22, 8'hDD, 0, C_LEAD, 5, 32);
        drain();
        hold(1'b1, 10);
        check("busy_after_bit_err", 32'(busy), 32'd0);
        hold(1'b1, 50);

        push(2'd3, 3'd4);
        hold(1'b0, C_LEAD);
        hold(1'b1, C_LHI);
        t0 = cyc_n;
        hold(1'b0, 750);
        ir = 1'b1;
        drain();
        check("timeout_delay", 32'((err_cyc - t0 >= 598) && (err_cyc - t0 <= 608)), 32'd1);
        hold(1'b1, 50);

        send_frame(16'h7777, 8'h01, 8'hFE, 0, C_LEAD, -1, 10);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_cleared("midreset");
        m_a = '0; m_c = '0;
        rst_n = 1'b1;
        hold(1'b1, 50);

        push(2'd3, 3'd5);
        send_rpt();
        drain();
        hold(1'b1, 50);

        m_a = 16'hC0DE; m_c = 8'h81;
        push(2'd1, 3'd0);
        send_frame(16'hC0DE, 8'h81, 8'h7E, 0, C_LEAD, -1, 32);
        drain();
        hold(1'b1, C_WIN + 100);

        push(2'd3, 3'd5);
        send_rpt();
        drain();
        hold(1'b1, 20);

        check("sb_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ir_nec_rx.md
# ir_nec_rx

Parametrised NEC infrared receiver, successor to the team's fixed-50 MHz IR decoder. Synchronises the demodulated receiver-head output, measures every low/high interval with one saturating counter, and decodes leader, 32 data bits, stop burst and repeat codes. Timing windows derive from the clock frequency and a tolerance parameter. Adds command-inverse checking, repeat-code reporting and error classification. Sits between the IR receiver pin and the user command logic (LED/segment display).

## Interface
- `CLK_HZ`, 50_000_000: clock frequency; all timing windows derive from it.
- `TOL_PCT`, 20: accepted deviation of each interval, in percent of nominal.
- `SYNC_STAGES`, 2: synchroniser depth on `iIR`; legal range 2..4.
- `CHECK_INV`, 1: 1 requires command byte == ~inverse byte; 0 skips the check.
- `REPEAT_WIN_MS`, 120: maximum delay from the last valid frame to an accepted repeat code.
- `Clk`  in  1: system clock.
- `Rst_n`  in  1: asynchronous, active-low reset.
- `iIR`  in  1: receiver-head output, idle high, active low.
- `irAddr`  out  16: address of the last valid frame, bits 15:0 of the frame; NEC and extended NEC are not distinguished.
- `irCmd`  out  8: command byte of the last valid frame.
- `frame_vld`  out  1: one-cycle pulse when a valid frame completes.
- `repeat_vld`  out  1: one-cycle pulse when an accepted repeat code completes.
- `err`  out  1: one-cycle pulse when decoding aborts.
- `err_code`  out  3: cause, held until the next `err`. 1 = leader timing, 2 = bit timing, 3 = inverse mismatch, 4 = timeout, 5 = orphan repeat.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- `iIR` passes through `SYNC_STAGES` flops, then one more flop for edge detection.
- A fall or rise edge presents `len`, the length of the level that just ended, in cycles. The counter clears on every edge and saturates at `T_TO` (12 ms).
- Nominal intervals are `N(us) = us*CLK_HZ/1_000_000`. An interval is accepted when `N*(100-TOL_PCT)/100 <= len <= N*(100+TOL_PCT)/100`. Bounds are computed at elaboration.
- Nominal values: 9000 us leader low, 4500 us leader high, 2250 us repeat high, 560 us burst, 560 us for a 0 space, 1690 us for a 1 space.
- States and transitions:
  - IDLE: fall -> LEAD_LO.
  - LEAD_LO: rise with len in the 9000 window -> LEAD_HI; otherwise err 1 -> IDLE.
  - LEAD_HI: fall with len in the 4500 window -> BIT_LO, bit index 0; len in the 2250 window -> RPT_LO; otherwise err 1 -> IDLE.
  - BIT_LO: rise with len in the 560 window -> BIT_HI, or STOP_HI after bit index 32; otherwise err 2.
  - BIT_HI: fall, shift in 0 (560 window) or 1 (1690 window) LSB-first, index+1 -> BIT_LO; otherwise err 2.
  - STOP_HI: entered on the rise ending the stop burst. Apply the inverse check; on pass, update `irAddr`/`irCmd` and pulse `frame_vld`; on fail, err 3. -> IDLE.
  - RPT_LO: rise with len in the 560 window. If the repeat timer is alive, pulse `repeat_vld`; otherwise err 5. -> IDLE.
- Timeout: the counter reaches `T_TO` in any non-IDLE state -> err 4 -> IDLE. In IDLE, saturation is silent.
- Repeat timer: a saturating counter loaded with `REPEAT_WIN_MS` on `frame_vld` and on `repeat_vld`, decremented each cycle down to 0. It is alive while non-zero.
- An aborted frame leaves `irAddr`/`irCmd` unchanged.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, sync flops 1 (idle line).
- Latency: a pin edge is seen `SYNC_STAGES+1` cycles later. `frame_vld`, `repeat_vld` and `err` assert on the cycle after that detected edge.
- `irAddr`/`irCmd` change in the same cycle as `frame_vld` and hold until the next valid frame.
- `frame_vld`, `repeat_vld` and `err` are mutually exclusive, at most one per cycle.
- Timeout and an edge in the same cycle: the edge wins and is evaluated against the saturated `len`, which fails every window.
- Reset mid-frame: immediate return to the reset values; no pulse is emitted.

## Structure
- Package `ir_nec_pkg`:
  - state enum;
  - `err_code` constants;
  - function `cyc(us, clk_hz)`;
  - window-bound function;
  - counter width `$clog2(T_TO+1)`.
- Sub-module `ir_pulse_timer`: synchroniser, edge detect, and saturating length counter. Outputs `fall`, `rise`, `len`, `sat`.
- Top level: FSM, shift register, inverse check, repeat timer.

## Test plan
- Frame addr 0x00FF, cmd 0x45 (inverse 0xBA) at 50 MHz with nominal timing -> one `frame_vld`; `irAddr`=0x00FF, `irCmd`=0x45.
- Same frame followed 40 ms later by a repeat code (9 ms / 2.25 ms / 560 us) -> `repeat_vld`; outputs unchanged.
- Repeat code with no prior frame since reset -> `err`, `err_code`=5, no `repeat_vld`.
- Inverse byte corrupted to 0xBB with `CHECK_INV`=1 -> `err_code`=3 and outputs hold their old values. With `CHECK_INV`=0 -> `frame_vld` and `irCmd`=0x45.
- All intervals stretched +18% -> decodes. Bit 5 space at 1200 us -> `err_code`=2, then IDLE.
- Line held low 15 ms after the leader -> `err_code`=4 at 12 ms. Assert `Rst_n` mid-data -> all outputs 0, and the next clean frame decodes.
